// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side bundle for the UART receiver.
//   rx_data    received byte, meaningful while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer accepts the byte (handshake on rx_valid & rx_ready)
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    sticky, a completed byte was dropped
//   parity_err one-cycle pulse, parity mismatch (0 unless parity is built in)
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1 frames (8E1 when UART_RX_PARITY_EN
// is defined), delivering bytes through a one-deep ready/valid holding register.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   rx   asynchronous serial line, idles high
//   bus  uart_rx_if.master: rx_data/rx_valid/rx_ready handshake plus
//        frame_err, overrun and parity_err status
// Parameter CLKS_PER_BIT: clocks per bit period, >= 4 and even.
// Option macro: UART_RX_PARITY_EN adds an even-parity bit and live parity_err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
  logic             par_flag_q, par_flag_d;
`endif
  logic             hs;
  logic             deliver;
  logic             line;

  // Next-state, datapath and holding-register update
  always_comb begin
    sync_d      = {sync_q[0], rx};
    prev_d      = sync_q[1];
    line        = sync_q[1];
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    hs          = rx_valid_q & bus.rx_ready;
    rx_valid_d  = rx_valid_q & ~hs;
    overrun_d   = overrun_q & ~hs;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_flag_d   = par_flag_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !line) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (cnt_q == CNT_HALF_END) begin
          state_d   = line ? S_IDLE : S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d     = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_BIT_END) begin
          par_flag_d = (line != (^shift_q));
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          state_d = S_IDLE;
          if (!line) begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_flag_q) begin
            parity_err_d = 1'b1;
          end
`endif
          else begin
            deliver = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // A byte accepted in this same cycle frees the register for the new one
    if (deliver) begin
      if (!rx_valid_q || hs) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_flag_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_flag_q   <= par_flag_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Falling pin at a driving point -> rx_valid seen at that many later sample points
  localparam int LAT = 3 + H + (PAR_EN ? 10 : 9) * N;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int v_cnt    = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 ns after the falling edge; checks happen there too
  task automatic wait_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par);
    rx = 1'b0;
    wait_n(N);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      wait_n(N);
    end
    if (PAR_EN) begin
      rx = par;
      wait_n(N);
    end
    rx = stop;
    wait_n(N);
    rx = 1'b1;
  endtask

  task automatic check_queue(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Observe the consumer side between edges: the values seen here are what the next edge uses
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.rx_valid) v_cnt++;
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
      if (bus.frame_err) fe_cnt++;
      if (bus.parity_err) pe_cnt++;
    end
  end

  initial begin
    int fe_exp;
    int pe_exp;
    int lat;
    int v0;
    int gap;
    logic [7:0] d;
    bit stop;
    bit par;

    fe_exp = 0;
    pe_exp = 0;
    rst = 1'b1;
    rx = 1'b1;
    bus.rx_ready = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(1);
    check("rst_rx_data",    32'(bus.rx_data),    32'h00);
    check("rst_rx_valid",   32'(bus.rx_valid),   32'h0);
    check("rst_frame_err",  32'(bus.frame_err),  32'h0);
    check("rst_overrun",    32'(bus.overrun),    32'h0);
    check("rst_parity_err", 32'(bus.parity_err), 32'h0);
    wait_n(4);

    // Single byte, latency and one-cycle valid with rx_ready held high
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        for (int i = 1; i <= 400; i++) begin
          wait_n(1);
          if (bus.rx_valid) begin
            lat = i;
            break;
          end
        end
        wait_n(1);
        check("a5_valid_one_cycle", 32'(bus.rx_valid), 32'h0);
      end
    join
    check("a5_latency", 32'(lat), 32'(LAT));
    exp_q.push_back(8'hA5);
    wait_n(4);
    check_queue("a5");

    // Stop bit low: frame error, nothing delivered
    v0 = v_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    fe_exp++;
    wait_n(N);
    check("fe_stop0_count", 32'(fe_cnt), 32'(fe_exp));
    check("fe_stop0_novalid", 32'(v_cnt), 32'(v0));

    // Break for three frame times gives one frame error, then normal reception
    rx = 1'b0;
    wait_n(30 * N);
    rx = 1'b1;
    fe_exp++;
    wait_n(N);
    check("break_fe_count", 32'(fe_cnt), 32'(fe_exp));
    send_frame(8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    wait_n(4);
    check_queue("after_break");

    // Short low glitch on idle line
    v0 = v_cnt;
    rx = 1'b0;
    wait_n(3);
    rx = 1'b1;
    wait_n(3 * N);
    check("glitch_novalid", 32'(v_cnt), 32'(v0));
    check("glitch_fe", 32'(fe_cnt), 32'(fe_exp));
    check("glitch_pe", 32'(pe_cnt), 32'(pe_exp));

    // Parity bit handling (even parity of 0x07 is 1)
    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1);
      exp_q.push_back(8'h07);
      wait_n(4);
      send_frame(8'h07, 1'b1, 1'b0);
      pe_exp++;
      wait_n(4);
      check_queue("parity");
      check("parity_pe_count", 32'(pe_cnt), 32'(pe_exp));
    end

    // Two frames with no consumer: first byte held, second dropped
    bus.rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_n(2);
    check("ovr_valid",   32'(bus.rx_valid), 32'h1);
    check("ovr_data",    32'(bus.rx_data),  32'h3C);
    check("ovr_overrun", 32'(bus.overrun),  32'h1);
    bus.rx_ready = 1'b1;
    wait_n(1);
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    check("ovr_hs_valid",   32'(bus.rx_valid), 32'h0);
    check("ovr_hs_overrun", 32'(bus.overrun),  32'h0);
    check_queue("overrun");

    // Reset mid-frame with a full register and overrun set
    send_frame(8'h66, 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0);
    wait_n(2);
    check("pre_rst_overrun", 32'(bus.overrun), 32'h1);
    fork
      send_frame(8'hF0, 1'b1, 1'b1);
      begin
        wait_n(5 * N + H);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        check("midrst_rx_data",  32'(bus.rx_data),   32'h00);
        check("midrst_rx_valid", 32'(bus.rx_valid),  32'h0);
        check("midrst_overrun",  32'(bus.overrun),   32'h0);
        check("midrst_fe",       32'(bus.frame_err), 32'h0);
      end
    join
    bus.rx_ready = 1'b1;
    wait_n(N);
    send_frame(8'h81, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    wait_n(4);
    check_queue("after_rst");
    check("after_rst_fe", 32'(fe_cnt), 32'(fe_exp));
    check("after_rst_pe", 32'(pe_cnt), 32'(pe_exp));

    // Random frames, mixed errors and back-to-back spacing, consumer always ready
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = (^d) ^ (PAR_EN && ($urandom_range(0, 4) == 0));
      if (!stop) fe_exp++;
      else if (PAR_EN && (par != (^d))) pe_exp++;
      else exp_q.push_back(d);
      send_frame(d, stop, par);
      gap = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(4, N));
      wait_n(gap);
    end
    wait_n(2 * N);
    check_queue("random");
    check("random_fe", 32'(fe_cnt), 32'(fe_exp));
    check("random_pe", 32'(pe_cnt), 32'(pe_exp));
    check("random_no_overrun", 32'(bus.overrun), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
